// File: rtl/libv_pkg.sv
// Shared helpers: ceiling log2 for index widths and the output slot state encoding.
package libv_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/libv_sadd_sat_core.sv
// Combinational signed adder clipped to the WO range; zero latency, no flow control.
module libv_sadd_sat_core #(
  parameter int WIA = 10,
  parameter int WIB = 8,
  parameter int WO  = 9
) (
  input  logic [WIA-1:0] i_a,
  input  logic [WIB-1:0] i_b,
  output logic [WO-1:0]  o_sum,
  output logic           o_sat
);

  localparam int WS = ((WIA > WIB) ? WIA : WIB) + 1;

  logic [WS-1:0] w_ea;
  logic [WS-1:0] w_eb;
  logic [WS-1:0] w_sum;

  assign w_ea  = {{(WS-WIA){i_a[WIA-1]}}, i_a};
  assign w_eb  = {{(WS-WIB){i_b[WIB-1]}}, i_b};
  assign w_sum = w_ea + w_eb;

  generate
    if (WO >= WS) begin : g_wide
      assign o_sum = WO'($signed(w_sum));
      assign o_sat = 1'b0;
    end else begin : g_narrow
      // The sum fits when every bit from the WO sign position upward agrees.
      logic w_fits;
      assign w_fits = (&w_sum[WS-1:WO-1]) | ~(|w_sum[WS-1:WO-1]);
      assign o_sat  = ~w_fits;
      assign o_sum  = w_fits        ? w_sum[WO-1:0] :
                      w_sum[WS-1]   ? {1'b1, {(WO-1){1'b0}}} :
                                      {1'b0, {(WO-1){1'b1}}};
    end
  endgenerate

endmodule

// File: rtl/libv_sadd_rr_sched.sv
// Round-robin share of one saturating adder; result one cycle after accept.
// One-entry output slot refills in the same cycle it drains; o_rdy=0 stalls all requesters.
module libv_sadd_rr_sched
  import libv_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int WIA  = 10,
  parameter  int WIB  = 8,
  parameter  int WO   = 9,
  localparam int WID  = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [NREQ*WIA-1:0] req_a,
  input  logic [NREQ*WIB-1:0] req_b,
  output logic [NREQ-1:0]     req_rdy,
  output logic                o_vld,
  input  logic                o_rdy,
  output logic [WO-1:0]       o_sum,
  output logic [WID-1:0]      o_id,
  output logic                o_sat,
  input  logic                sat_clr,
  output logic [15:0]         sat_cnt
);

  slot_state_t    r_state;
  logic [WO-1:0]  r_sum;
  logic [WID-1:0] r_id;
  logic           r_sat;
  logic [15:0]    r_cnt;
  logic [WID-1:0] r_ptr;

  logic           w_ld;
  logic           w_any;
  logic           w_acc;
  logic [WID-1:0] w_g;
  logic [WID:0]   w_idx;
  logic [WIA-1:0] w_a;
  logic [WIB-1:0] w_b;
  logic [WO-1:0]  w_sum;
  logic           w_sat;
  logic [NREQ-1:0] w_rdy;

  assign w_ld  = (r_state == ST_EMPTY) | o_rdy;
  assign w_acc = w_any & w_ld;

  // First valid requester at or after r_ptr, wrapping past NREQ-1.
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (WID+1)'(k);
      if (w_idx >= (WID+1)'(NREQ)) w_idx = w_idx - (WID+1)'(NREQ);
      if (!w_any && req_vld[w_idx[WID-1:0]]) begin
        w_any = 1'b1;
        w_g   = w_idx[WID-1:0];
      end
    end
  end

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_g == WID'(i)) begin
        w_a      = req_a[i*WIA +: WIA];
        w_b      = req_b[i*WIB +: WIB];
        w_rdy[i] = rst_n & w_acc;
      end
    end
  end

  libv_sadd_sat_core #(
    .WIA (WIA),
    .WIB (WIB),
    .WO  (WO)
  ) u_core (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_sum   <= '0;
      r_id    <= '0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_acc) begin
        r_state <= ST_FULL;
        r_sum   <= w_sum;
        r_id    <= w_g;
        r_sat   <= w_sat;
        r_ptr   <= (w_g == WID'(NREQ-1)) ? '0 : w_g + 1'b1;
      end else if (o_rdy) begin
        r_state <= ST_EMPTY;
      end
      // Clear wins over the count, but a saturated accept in the same cycle still counts once.
      if (sat_clr) begin
        r_cnt <= (w_acc & w_sat) ? 16'd1 : 16'd0;
      end else if (w_acc && w_sat && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign req_rdy = w_rdy;
  assign o_vld   = (r_state == ST_FULL);
  assign o_sum   = r_sum;
  assign o_id    = r_id;
  assign o_sat   = r_sat;
  assign sat_cnt = r_cnt;

endmodule

// File: doc/libv_sadd_rr_sched.md
# libv_sadd_rr_sched

Round-robin scheduler that time-shares a single saturating signed adder between `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants at most one requester per cycle, computes the saturated sum, and holds it in a one-entry output register with valid/ready backpressure, tagged with the requester index. It also raises a per-result saturation flag and keeps a saturating saturation-event counter for status readout. It sits between multiple DSP lanes and a shared downstream consumer wherever one adder is cheaper than `NREQ` adders.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..16).
- `WIA`, 10, width of signed operand a.
- `WIB`, 8, width of signed operand b.
- `WO`, 9, width of signed result. The sum is saturated to the `WO` range.
- `WID`, derived as clog2(`NREQ`) with a minimum of 1, width of the requester index. It is not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `req_vld`  in  `NREQ`  per-requester operand valid.
- `req_a`  in  `NREQ*WIA`  packed operands a; requester i occupies bits [i*WIA +: WIA].
- `req_b`  in  `NREQ*WIB`  packed operands b; requester i occupies bits [i*WIB +: WIB].
- `req_rdy`  out  `NREQ`  per-requester accept, one-hot or zero.
- `o_vld`  out  1  result valid.
- `o_rdy`  in  1  downstream ready.
- `o_sum`  out  `WO`  saturated signed sum.
- `o_id`  out  `WID`  index of the requester that produced `o_sum`.
- `o_sat`  out  1  `o_sum` was clipped.
- `sat_clr`  in  1  clear saturation counter.
- `sat_cnt`  out  16  count of saturated results accepted.

## Operation
- Output slot states: EMPTY (`o_vld`=0) and FULL (`o_vld`=1).
- Load enable: `ld` = !`o_vld` | `o_rdy`.
- Arbitration: search `req_vld` starting at pointer `ptr`, ascending with wrap, and take the first set bit g.
  - `req_rdy`[g] = `ld`; all other bits of `req_rdy` are 0.
  - With no valid requester, `req_rdy` = 0.
- Accept (a requester handshake): load `o_sum`, `o_id`=g and `o_sat`, set `o_vld`, and set `ptr` = (g+1) mod `NREQ`.
- No accept: `ptr` is unchanged.
- Drain without accept (`o_vld` & `o_rdy` and no valid requester): clear `o_vld`. `o_sum`, `o_id` and `o_sat` hold their last values.
- Held data: `o_sum`, `o_id` and `o_sat` are stable while `o_vld` & !`o_rdy`.
- Arithmetic:
  - Sign-extend a and b to max(`WIA`,`WIB`)+1 bits and add.
  - If the sum fits `WO` signed, `o_sum` is the sum and `o_sat`=0.
  - Otherwise `o_sum` is the signed max (0 followed by all 1s) for a positive sum, or the signed min (1 followed by all 0s) for a negative sum, and `o_sat`=1.
  - If `WO` ≥ the sum width, `o_sum` is the sign-extended sum and `o_sat` is always 0.
- Counter:
  - On an accept with a saturated result, `sat_cnt` increments. It holds at 16'hFFFF.
  - `sat_clr` zeroes `sat_cnt`.
  - `sat_clr` coinciding with a saturated accept gives `sat_cnt`=1.
- `req_vld` must not depend on `req_rdy`. `req_rdy` depends combinationally on `req_vld`, `ptr`, `o_vld` and `o_rdy`.

## Timing
- Reset (`rst_n`=0 at a clock edge): `o_vld`=0, `o_sum`=0, `o_id`=0, `o_sat`=0, `sat_cnt`=0, `ptr`=0.
  - `req_rdy` is forced to 0 while `rst_n`=0.
  - Reset asserted mid-operation discards the held result; no handshake completes in that cycle.
- Latency: result is visible on `o_vld`/`o_sum` the cycle after the accept edge.
- Throughput: one result per cycle with `o_rdy` held at 1.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one with no bubble.
- Fairness: a continuously valid requester is granted within `NREQ` accepts.

## Structure
- Shared package `libv_pkg`: clog2 function and the EMPTY/FULL state constants.
- Sub-module `libv_sadd_sat_core`: combinational saturating adder with parameters `WIA`/`WIB`/`WO` and outputs sum and sat flag.
- Top level contains the round-robin arbiter, the output register and the counter. The arbiter stays inline.

## Test plan
1. Reset behaviour: `rst_n`=0 for 3 cycles with `req_vld`=4'hF and `o_rdy`=1 → `req_rdy`=0, `o_vld`=0, `sat_cnt`=0. After release, the first grant goes to requester 0.
2. Single, unsaturated: requester 1 only, a=100, b=−50 → next cycle `o_vld`=1, `o_sum`=9'd50, `o_id`=1, `o_sat`=0.
3. Saturation, positive then negative: a=200, b=100 → `o_sum`=9'h0FF, `o_sat`=1, `sat_cnt`=1. Then a=−512, b=−128 → `o_sum`=9'h100, `o_sat`=1, `sat_cnt`=2.
4. Round-robin order: `req_vld`=4'hF held, `o_rdy`=1 → `o_id` sequence 0,1,2,3,0,1. Then `req_vld`=4'b1010 → `o_id` sequence 3,1,3.
5. Backpressure: `o_rdy`=0 for 2 cycles while FULL → `o_sum`/`o_id` stable and `req_rdy`=0. On `o_rdy`=1 with requester 2 valid: drain and accept in the same cycle, and `o_vld` stays 1.
6. Counter edges: preload `sat_cnt`=16'hFFFF via 65535 saturated accepts (or force) → a further saturated accept holds 16'hFFFF. `sat_clr` together with a saturated accept → `sat_cnt`=1.
